// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings, EX hazard FSM states,
// register-index width and small elaboration-time helpers.
package pipe_pkg;

   localparam int REG_W = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_CMP = 4'h1;
   localparam logic [3:0] OP_BEQ = 4'h2;
   localparam logic [3:0] OP_BGT = 4'h3;
   localparam logic [3:0] OP_B   = 4'h4;
   localparam logic [3:0] OP_MUL = 4'h5;
   localparam logic [3:0] OP_LD  = 4'h6;
   localparam logic [3:0] OP_ST  = 4'h7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      FLUSH    = 2'd2
   } state_e;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/flag_reg.sv
// CMP comparator and E/GT condition-flag register.
// Ports: clk, reset (sync, high), en (load), a/b operands, flag_e, flag_gt.
module flag_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              flag_e,
   output logic              flag_gt
);

   logic e_d, e_q;
   logic gt_d, gt_q;

   always_comb begin
      e_d  = e_q;
      gt_d = gt_q;
      if (en) begin
         e_d  = (a == b);
         gt_d = ($signed(a) > $signed(b));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q  <= 1'b0;
         gt_q <= 1'b0;
      end else begin
         e_q  <= e_d;
         gt_q <= gt_d;
      end
   end

   assign flag_e  = e_q;
   assign flag_gt = gt_q;

endmodule

// File: rtl/branch_hazard_unit.sv
// EX-stage branch resolution and hazard control: flags, branch redirect,
// MUL occupancy stall, load-use stall. Outputs stall/is_branch_taken/branch_pc.
module branch_hazard_unit
   import pipe_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int PC_W         = 32,
   parameter int MUL_LAT      = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              iscmp,
   input  logic              isbeq,
   input  logic              isbgt,
   input  logic              isubranch,
   input  logic              ismul,
   input  logic              isld,
   input  logic              iswb,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [DATA_W-1:0] cmp_a,
   input  logic [DATA_W-1:0] cmp_b,
   input  logic [PC_W-1:0]   ex_target,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   output logic              stall,
   output logic              is_branch_taken,
   output logic [PC_W-1:0]   branch_pc,
   output logic              flag_e,
   output logic              flag_gt
);

   localparam int CNT_W = $clog2(max_i(MUL_LAT, FLUSH_CYCLES)) + 1;
   localparam bit MUL_STALLS = (MUL_LAT > 1);
   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e            state_d, state_q;
   logic [CNT_W-1:0]  mcnt_d, mcnt_q;
   logic [CNT_W-1:0]  fcnt_d, fcnt_q;
   logic              ibt_d, ibt_q;
   logic [PC_W-1:0]   bpc_d, bpc_q;

   logic act;
   logic take;
   logic mul_start;
   logic lu;

   // EX inputs only count while the FSM is idle
   assign act = ex_valid & (state_q == IDLE);

   flag_reg #(.DATA_W(DATA_W)) u_flags (
      .clk     (clk),
      .reset   (reset),
      .en      (act & iscmp),
      .a       (cmp_a),
      .b       (cmp_b),
      .flag_e  (flag_e),
      .flag_gt (flag_gt)
   );

   // Conditions use the registered flags, so CMP->BEQ back-to-back works
   assign take = act & (isubranch
                      | (isbeq & flag_e)
                      | (isbgt & flag_gt));

   assign mul_start = act & ismul & MUL_STALLS;

   assign lu = act & isld & iswb
             & ((id_use_rs1 & (id_rs1 == ex_rd))
              | (id_use_rs2 & (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mcnt_q  <= '0;
         fcnt_q  <= '0;
         ibt_q   <= 1'b0;
         bpc_q   <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         fcnt_q  <= fcnt_d;
         ibt_q   <= ibt_d;
         bpc_q   <= bpc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      fcnt_d  = fcnt_q;
      ibt_d   = ibt_q;
      bpc_d   = bpc_q;
      unique case (state_q)
         IDLE: begin
            if (take) begin
               bpc_d   = ex_target;
               ibt_d   = 1'b1;
               fcnt_d  = FLUSH_INIT;
               state_d = FLUSH;
            end else if (mul_start) begin
               mcnt_d  = MUL_INIT;
               state_d = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            mcnt_d = mcnt_q - ONE;
            if (mcnt_q == ONE) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0) begin
               ibt_d   = 1'b0;
               state_d = IDLE;
            end else begin
               fcnt_d = fcnt_q - ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Final MUL_BUSY cycle drops stall so the MUL can leave EX
   always_comb begin
      stall = 1'b0;
      unique case (state_q)
         IDLE:     stall = (mul_start | lu) & ~take;
         MUL_BUSY: stall = (mcnt_q > ONE);
         FLUSH:    stall = 1'b0;
         default:  stall = 1'b0;
      endcase
   end

   assign is_branch_taken = ibt_q;
   assign branch_pc       = bpc_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed self-checking bench for branch_hazard_unit.
// Second instance uses MUL_LAT=1 to cover the no-stall MUL case.
module tb_branch_hazard_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic        iscmp, isbeq, isbgt, isubranch;
   logic        ismul, isld, iswb;
   logic [3:0]  ex_rd;
   logic [31:0] cmp_a, cmp_b, ex_target;
   logic [3:0]  id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2;

   logic        stall, ibt, fe, fgt;
   logic [31:0] bpc;
   logic        s1, ibt1, fe1, fgt1;
   logic [31:0] bpc1;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_hazard_unit dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid),
      .iscmp(iscmp), .isbeq(isbeq), .isbgt(isbgt),
      .isubranch(isubranch), .ismul(ismul), .isld(isld),
      .iswb(iswb), .ex_rd(ex_rd), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .ex_target(ex_target), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .stall(stall), .is_branch_taken(ibt), .branch_pc(bpc),
      .flag_e(fe), .flag_gt(fgt)
   );

   branch_hazard_unit #(.MUL_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .ex_valid(ex_valid),
      .iscmp(iscmp), .isbeq(isbeq), .isbgt(isbgt),
      .isubranch(isubranch), .ismul(ismul), .isld(isld),
      .iswb(iswb), .ex_rd(ex_rd), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .ex_target(ex_target), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .stall(s1), .is_branch_taken(ibt1), .branch_pc(bpc1),
      .flag_e(fe1), .flag_gt(fgt1)
   );

   task automatic clr();
      ex_valid = 0; iscmp = 0; isbeq = 0; isbgt = 0;
      isubranch = 0; ismul = 0; isld = 0; iswb = 0;
      ex_rd = 0; cmp_a = 0; cmp_b = 0; ex_target = 0;
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; clr();
      tick(); tick();
      reset = 0; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL rst_stall got=%0b want=0", stall); n_fail++;
      end
      n_checks++;
      if (ibt !== 1'b0) begin
         $display("FAIL rst_ibt got=%0b want=0", ibt); n_fail++;
      end
      n_checks++;
      if (bpc !== 32'h0) begin
         $display("FAIL rst_pc got=%h want=0", bpc); n_fail++;
      end
      n_checks++;
      if ({fe, fgt} !== 2'b00) begin
         $display("FAIL rst_flags got=%b want=00", {fe, fgt}); n_fail++;
      end
   endtask

   task automatic test_reset_mid_ops();
      // reset while in MUL_BUSY
      ex_valid = 1; ismul = 1; #1;
      tick();
      n_checks++;
      if (stall !== 1'b1) begin
         $display("FAIL rm_busy_stall got=%0b want=1", stall); n_fail++;
      end
      reset = 1; clr();
      tick(); tick();
      reset = 0; #1;
      n_checks++;
      if ({stall, ibt} !== 2'b00) begin
         $display("FAIL rm_after got=%b want=00", {stall, ibt}); n_fail++;
      end
      // ADD afterwards must not stall
      ex_valid = 1; iswb = 1; ex_rd = 3;
      id_rs1 = 3; id_use_rs1 = 1; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL rm_add_stall got=%0b want=0", stall); n_fail++;
      end
      clr(); tick();
      // reset while in FLUSH
      ex_valid = 1; isubranch = 1; ex_target = 32'h55; #1;
      tick();
      n_checks++;
      if (ibt !== 1'b1 || bpc !== 32'h55) begin
         $display("FAIL rf_take got=%0b/%h want=1/55", ibt, bpc);
         n_fail++;
      end
      reset = 1; clr();
      tick();
      reset = 0;
      n_checks++;
      if ({stall, ibt} !== 2'b00 || bpc !== 32'h0) begin
         $display("FAIL rf_after got=%b/%h want=00/0",
                  {stall, ibt}, bpc);
         n_fail++;
      end
      tick(); tick();
   endtask

   task automatic test_cmp_beq();
      ex_valid = 1; iscmp = 1; cmp_a = 5; cmp_b = 5; #1;
      tick();
      n_checks++;
      if ({fe, fgt} !== 2'b10 || {fe1, fgt1} !== 2'b10) begin
         $display("FAIL cmp55_flags got=%b/%b want=10",
                  {fe, fgt}, {fe1, fgt1});
         n_fail++;
      end
      clr();
      ex_valid = 1; isbeq = 1; ex_target = 32'h40; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL beq_stall got=%0b want=0", stall); n_fail++;
      end
      tick();
      n_checks++;
      if (ibt !== 1'b1 || bpc !== 32'h40 || ibt1 !== 1'b1) begin
         $display("FAIL beq_f1 got=%0b/%h want=1/40", ibt, bpc);
         n_fail++;
      end
      // garbage during flush must be ignored
      clr();
      ex_valid = 1; isubranch = 1; ismul = 1; iscmp = 1;
      ex_target = 32'h80; cmp_a = 1; cmp_b = 2; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL flush_stall got=%0b want=0", stall); n_fail++;
      end
      tick();
      n_checks++;
      if (ibt !== 1'b1 || bpc !== 32'h40) begin
         $display("FAIL beq_f2 got=%0b/%h want=1/40", ibt, bpc);
         n_fail++;
      end
      clr();
      tick();
      n_checks++;
      if (ibt !== 1'b0 || bpc1 !== 32'h40) begin
         $display("FAIL beq_end got=%0b want=0", ibt); n_fail++;
      end
      n_checks++;
      if ({fe, fgt} !== 2'b10) begin
         $display("FAIL flush_flags got=%b want=10", {fe, fgt});
         n_fail++;
      end
   endtask

   task automatic test_bgt();
      ex_valid = 1; iscmp = 1; cmp_a = 32'hFFFF_FFFF; cmp_b = 3; #1;
      tick();
      n_checks++;
      if ({fe, fgt} !== 2'b00) begin
         $display("FAIL cmp_m1_3 got=%b want=00", {fe, fgt}); n_fail++;
      end
      clr();
      ex_valid = 1; isbgt = 1; ex_target = 32'h100; #1;
      tick();
      n_checks++;
      if (ibt !== 1'b0) begin
         $display("FAIL bgt_nt got=%0b want=0", ibt); n_fail++;
      end
      clr();
      ex_valid = 1; iscmp = 1; cmp_a = 7; cmp_b = 3; #1;
      tick();
      n_checks++;
      if ({fe, fgt} !== 2'b01) begin
         $display("FAIL cmp_7_3 got=%b want=01", {fe, fgt}); n_fail++;
      end
      clr();
      ex_valid = 1; isbgt = 1; ex_target = 32'h100; #1;
      tick();
      n_checks++;
      if (ibt !== 1'b1 || bpc !== 32'h100) begin
         $display("FAIL bgt_t got=%0b/%h want=1/100", ibt, bpc);
         n_fail++;
      end
      clr();
      tick(); tick();
   endtask

   task automatic test_mul();
      ex_valid = 1; ismul = 1; #1;
      n_checks++;
      if (stall !== 1'b1 || s1 !== 1'b0) begin
         $display("FAIL mul_c0 got=%0b/%0b want=1/0", stall, s1);
         n_fail++;
      end
      tick();
      n_checks++;
      if (stall !== 1'b1 || s1 !== 1'b0) begin
         $display("FAIL mul_c1 got=%0b/%0b want=1/0", stall, s1);
         n_fail++;
      end
      tick();
      n_checks++;
      if (stall !== 1'b0 || s1 !== 1'b0) begin
         $display("FAIL mul_c2 got=%0b/%0b want=0/0", stall, s1);
         n_fail++;
      end
      clr();
      tick(); tick();
   endtask

   task automatic test_load_use();
      ex_valid = 1; isld = 1; iswb = 1; ex_rd = 4;
      id_rs2 = 4; id_use_rs2 = 1; #1;
      n_checks++;
      if (stall !== 1'b1) begin
         $display("FAIL lu_rs2 got=%0b want=1", stall); n_fail++;
      end
      tick();
      ex_valid = 0; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL lu_bubble got=%0b want=0", stall); n_fail++;
      end
      ex_valid = 1; id_use_rs2 = 0; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL lu_nouse got=%0b want=0", stall); n_fail++;
      end
      id_rs1 = 4; id_use_rs1 = 1; #1;
      n_checks++;
      if (stall !== 1'b1) begin
         $display("FAIL lu_rs1 got=%0b want=1", stall); n_fail++;
      end
      clr();
      tick();
   endtask

   task automatic test_branch_priority();
      ex_valid = 1; isubranch = 1; ex_rd = 4;
      id_rs2 = 4; id_use_rs2 = 1; ex_target = 32'h200; #1;
      n_checks++;
      if (stall !== 1'b0) begin
         $display("FAIL br_pri_stall got=%0b want=0", stall); n_fail++;
      end
      tick();
      n_checks++;
      if (ibt !== 1'b1 || bpc !== 32'h200) begin
         $display("FAIL br_pri_take got=%0b/%h want=1/200", ibt, bpc);
         n_fail++;
      end
      clr();
      tick(); tick();
      n_checks++;
      if (ibt !== 1'b0) begin
         $display("FAIL br_pri_end got=%0b want=0", ibt); n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_ops();
      test_cmp_beq();
      test_bgt();
      test_mul();
      test_load_use();
      test_branch_priority();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

Execute-stage branch resolution and hazard controller for the decode/execute pipeline. It consumes the registered one-hot control bits of the instruction currently in EX (iscmp, isbeq, isbgt, isubranch, ismul, isld, iswb) and keeps the E/GT condition flags. It produces the `stall` and `is_branch_taken` inputs that the decode control unit and fetch stage consume, so it closes the loop opposite the opcode decoder.

## Interface
- DATA_W, 32, compare operand width
- PC_W, 32, branch target width
- MUL_LAT, 3, cycles a MUL occupies EX (≥1)
- FLUSH_CYCLES, 2, cycles `is_branch_taken` is held (≥1)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX holds a real instruction
- iscmp, isbeq, isbgt, isubranch, ismul, isld, iswb  in  1 each  EX control bits
- ex_rd  in  4  EX destination register
- cmp_a, cmp_b  in  DATA_W  CMP operands (two's complement)
- ex_target  in  PC_W  branch target of EX instruction
- id_rs1, id_rs2  in  4  ID source registers
- id_use_rs1, id_use_rs2  in  1  ID actually reads rs1/rs2
- stall  out  1  freeze IF, ID and EX input register
- is_branch_taken  out  1  squash IF/ID and clear decoded controls
- branch_pc  out  PC_W  redirect PC, valid while is_branch_taken
- flag_e, flag_gt  out  1  condition flags

## Operation
- Reset: state IDLE, counters 0; stall, is_branch_taken, flag_e, flag_gt = 0; branch_pc = 0.
- States: IDLE, MUL_BUSY, FLUSH.
- "act" = ex_valid & state==IDLE. EX inputs are ignored in MUL_BUSY and FLUSH.
- Flags: on act & iscmp, flag_e <= (cmp_a==cmp_b) and flag_gt <= signed(cmp_a) > signed(cmp_b). Otherwise the flags hold.
- take = act & (isubranch | isbeq&flag_e | isbgt&flag_gt), using the registered flags. A CMP directly followed by BEQ therefore sees the new flags.
- take: branch_pc <= ex_target, is_branch_taken <= 1, fcnt <= FLUSH_CYCLES-1, go to FLUSH. FLUSH: is_branch_taken stays 1; fcnt decrements; at fcnt==0, is_branch_taken <= 0 and go to IDLE.
- MUL: act & ismul with MUL_LAT>1 gives stall=1 this cycle, mcnt <= MUL_LAT-1, go to MUL_BUSY. In MUL_BUSY, stall = (mcnt>1) and mcnt decrements. At mcnt==1 go to IDLE with stall=0, so the MUL leaves EX. MUL_LAT==1 never stalls.
- Load-use: lu = act & isld & iswb & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). lu gives stall=1 for exactly that cycle. The next cycle the load has left EX, because EX receives a bubble.
- stall = (IDLE & (mul_start | lu) & !take) | (MUL_BUSY & mcnt>1). It is forced to 0 in FLUSH.
- Priority: take > mul_start > lu. A single instruction carries one class only.

## Timing
- Flags are visible 1 cycle after CMP is in EX.
- A branch in EX at cycle t gives is_branch_taken=1 in cycles t+1 through t+FLUSH_CYCLES. branch_pc is stable over that window.
- stall (combinational from registered state and EX/ID inputs) is asserted in the same cycle as the hazard.
- A MUL in EX at t gives stall=1 in t through t+MUL_LAT-2 and stall=0 in t+MUL_LAT-1.
- A branch seen while stalling cannot occur, because EX inputs are ignored.
- Reset mid-FLUSH or mid-MUL_BUSY: all outputs are 0 at the next edge.

## Structure
- Shared package `pipe_pkg`: opcode localparams, state enum {IDLE, MUL_BUSY, FLUSH}, register-index width (4).
- Sub-module `flag_reg`: CMP comparator plus E/GT register with an enable.
- Core FSM and both counters live in branch_hazard_unit. Counter width is $clog2(max(MUL_LAT, FLUSH_CYCLES))+1.

## Test plan
- Reset: assert reset for 2 cycles mid-MUL_BUSY → all outputs 0, state IDLE; a following ADD produces no stall.
- CMP a=5, b=5 then BEQ target 0x40 → flag_e=1, flag_gt=0; is_branch_taken=1 for exactly 2 cycles, branch_pc=0x40; EX inputs ignored during the flush.
- CMP a=-1, b=3 then BGT → flag_gt=0, no branch; CMP a=7, b=3 then BGT → branch taken.
- MUL with MUL_LAT=3 → stall 1,1,0 over three cycles; MUL_LAT=1 → no stall.
- LD with ex_rd=4 while ID has id_rs2=4 and id_use_rs2=1 → stall for one cycle; id_use_rs2=0 → no stall.
- Unconditional branch while ID has a load-use match → stall=0 and is_branch_taken next cycle (branch has priority).
